alu_issue_ctrl: RTL and testbench

Multi-cycle issue controller that sits in front of the custom processor's combinational `alu` and drives its `A`, `B` and `opcode` operands, instead of the ALU being driven by testbench stimulus. It accepts 16-bit instruction words over a valid/ready handshake, reads operands from a 4-entry register file, and issues one ALU operation. It captures `alu_out` into that register file and returns the written value over a second valid/ready handshake.

---
 rtl/alu_issue_ctrl.sv | 196 +++++++++++++++++++
 tb/tb_alu_issue_ctrl.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: multi-cycle issue controller in front of a combinational ALU.
// Accepts 16-bit instruction words, reads operands from a 4-entry register
// file, drives the ALU for one EXEC cycle, writes the ALU result back and
// returns it over a valid/ready result channel.
// Optional feature: define ALU_FLAGS_EN to build the zero/negative flag
// registers; without it flag_z/flag_n are tied to 0.
module alu_issue_ctrl #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             instr_valid,
    output logic             instr_ready,
    input  logic [15:0]      instr,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [1:0]       alu_op,
    input  logic [WIDTH-1:0] alu_result,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_data,
    output logic [1:0]       res_rd,
    output logic             flag_z,
    output logic             flag_n
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_WB   = 2'd2,
        S_RESP = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [1:0]       rd_q, rd_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [WIDTH-1:0] rf_q [4];

    logic             instr_ready_q, instr_ready_d;
    logic             res_valid_q, res_valid_d;
    logic [WIDTH-1:0] res_data_q, res_data_d;
    logic [1:0]       res_rd_q, res_rd_d;
    logic [WIDTH-1:0] alu_a_q, alu_a_d;
    logic [WIDTH-1:0] alu_b_q, alu_b_d;
    logic [1:0]       alu_op_q, alu_op_d;

    logic             accept_s;
    logic             res_hs_s;
    logic [WIDTH-1:0] imm_ext_s;

    assign accept_s  = (state_q == S_IDLE) & instr_valid & instr_ready_q;
    assign res_hs_s  = res_valid_q & res_ready;
    assign imm_ext_s = {{(WIDTH-7){1'b0}}, instr[6:0]};

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: IDLE -> EXEC -> WB -> RESP -> IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (accept_s) begin
                    state_d = S_EXEC;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_EXEC: state_d = S_WB;
            S_WB:   state_d = S_RESP;
            S_RESP: begin
                if (res_hs_s) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_RESP;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Output/datapath next values. ALU operands are loaded at the accept edge
    // so they are presented from a register during the single EXEC cycle;
    // the register file cannot change between accept and EXEC, so this is
    // the same as reading it in EXEC.
    always_comb begin
        alu_a_d       = {WIDTH{1'b0}};
        alu_b_d       = {WIDTH{1'b0}};
        alu_op_d      = 2'd0;
        rd_d          = rd_q;
        result_d      = result_q;
        res_data_d    = res_data_q;
        res_rd_d      = res_rd_q;
        instr_ready_d = (state_d == S_IDLE);
        res_valid_d   = (state_d == S_RESP);

        if (accept_s) begin
            alu_a_d  = rf_q[instr[10:9]];
            alu_b_d  = instr[13] ? imm_ext_s : rf_q[instr[8:7]];
            alu_op_d = instr[15:14];
            rd_d     = instr[12:11];
        end else begin
            alu_a_d  = {WIDTH{1'b0}};
            alu_b_d  = {WIDTH{1'b0}};
            alu_op_d = 2'd0;
            rd_d     = rd_q;
        end

        if (state_q == S_EXEC) begin
            result_d = alu_result;
        end else begin
            result_d = result_q;
        end

        if (state_q == S_WB) begin
            res_data_d = result_q;
            res_rd_d   = rd_q;
        end else begin
            res_data_d = res_data_q;
            res_rd_d   = res_rd_q;
        end
    end

    // Output and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instr_ready_q <= 1'b1;
            res_valid_q   <= 1'b0;
            res_data_q    <= {WIDTH{1'b0}};
            res_rd_q      <= 2'd0;
            alu_a_q       <= {WIDTH{1'b0}};
            alu_b_q       <= {WIDTH{1'b0}};
            alu_op_q      <= 2'd0;
            rd_q          <= 2'd0;
            result_q      <= {WIDTH{1'b0}};
        end else begin
            instr_ready_q <= instr_ready_d;
            res_valid_q   <= res_valid_d;
            res_data_q    <= res_data_d;
            res_rd_q      <= res_rd_d;
            alu_a_q       <= alu_a_d;
            alu_b_q       <= alu_b_d;
            alu_op_q      <= alu_op_d;
            rd_q          <= rd_d;
            result_q      <= result_d;
        end
    end

    // Register file: cleared on reset, written with the captured result in WB.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                rf_q[i] <= {WIDTH{1'b0}};
            end
        end else if (state_q == S_WB) begin
            rf_q[rd_q] <= result_q;
        end
    end

`ifdef ALU_FLAGS_EN
    logic flag_z_q;
    logic flag_n_q;

    // Zero/negative flags of the most recent writeback.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flag_z_q <= 1'b0;
            flag_n_q <= 1'b0;
        end else if (state_q == S_WB) begin
            flag_z_q <= (result_q == {WIDTH{1'b0}});
            flag_n_q <= result_q[WIDTH-1];
        end
    end

    assign flag_z = flag_z_q;
    assign flag_n = flag_n_q;
`else
    assign flag_z = 1'b0;
    assign flag_n = 1'b0;
`endif

    assign instr_ready = instr_ready_q;
    assign res_valid   = res_valid_q;
    assign res_data    = res_data_q;
    assign res_rd      = res_rd_q;
    assign alu_a       = alu_a_q;
    assign alu_b       = alu_b_q;
    assign alu_op      = alu_op_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Self-checking bench for alu_issue_ctrl with a behavioural ALU attached.
module tb_alu_issue_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        instr_valid = 1'b0;
    logic        instr_ready;
    logic [15:0] instr = 16'h0000;
    logic [15:0] alu_a, alu_b, alu_result;
    logic [1:0]  alu_op;
    logic        res_valid;
    logic        res_ready = 1'b1;
    logic [15:0] res_data;
    logic [1:0]  res_rd;
    logic        flag_z, flag_n;

    int n_cmp = 0;
    int n_bad = 0;

`ifdef ALU_FLAGS_EN
    localparam bit FLAGS_EN = 1'b1;
`else
    localparam bit FLAGS_EN = 1'b0;
`endif

    alu_issue_ctrl #(.WIDTH(16)) dut (
        .clk(clk), .rst(rst),
        .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_result(alu_result),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_data(res_data), .res_rd(res_rd),
        .flag_z(flag_z), .flag_n(flag_n)
    );

    always #5 clk = ~clk;

    // The ALU the controller drives.
    always_comb begin
        case (alu_op)
            2'd0:    alu_result = alu_a + alu_b;
            2'd1:    alu_result = alu_a - alu_b;
            2'd2:    alu_result = alu_a & alu_b;
            2'd3:    alu_result = alu_a | alu_b;
            default: alu_result = 16'h0000;
        endcase
    end

    // Reference model state: architectural register file.
    int rf_m [4];

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    function automatic logic [15:0] enc(input logic [1:0] op, input logic im, input logic [1:0] rd,
                                        input logic [1:0] rs1, input logic [1:0] rs2, input logic [6:0] i7);
        return {op, im, rd, rs1, rs2, i7};
    endfunction

    function automatic int model_a(input logic [15:0] ins);
        return rf_m[ins[10:9]];
    endfunction

    function automatic int model_b(input logic [15:0] ins);
        int v;
        v = ins[13] ? int'(ins[6:0]) : rf_m[ins[8:7]];
        return v;
    endfunction

    function automatic int model_res(input logic [15:0] ins);
        int a, b, r;
        a = model_a(ins);
        b = model_b(ins);
        case (ins[15:14])
            2'd0:    r = (a + b) % 65536;
            2'd1:    r = (a - b + 65536) % 65536;
            2'd2:    r = a & b;
            default: r = a | b;
        endcase
        return r;
    endfunction

    // Issue one instruction and follow it through EXEC, WB and RESP.
    task automatic run_instr(input logic [15:0] ins, input logic [15:0] exp_d, input int hold,
                             input logic [15:0] next_ins, input bit next_valid);
        int n;
        logic [15:0] ea, eb;
        ea = 16'(model_a(ins));
        eb = 16'(model_b(ins));
        n = 0;
        while (!instr_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("ready_wait", {31'd0, instr_ready}, 32'd1);
        instr       = ins;
        instr_valid = 1'b1;
        res_ready   = (hold == 0);
        @(negedge clk);                       // cycle 1: EXEC
        instr_valid = next_valid;
        instr       = next_ins;
        chk("exec_ready", {31'd0, instr_ready}, 32'd0);
        chk("exec_valid", {31'd0, res_valid}, 32'd0);
        chk("exec_a", {16'd0, alu_a}, {16'd0, ea});
        chk("exec_b", {16'd0, alu_b}, {16'd0, eb});
        chk("exec_op", {30'd0, alu_op}, {30'd0, ins[15:14]});
        @(negedge clk);                       // cycle 2: WB
        chk("wb_valid", {31'd0, res_valid}, 32'd0);
        chk("wb_alu_a_zero", {16'd0, alu_a | alu_b}, 32'd0);
        @(negedge clk);                       // cycle 3: RESP
        chk("resp_valid", {31'd0, res_valid}, 32'd1);
        chk("resp_data", {16'd0, res_data}, {16'd0, exp_d});
        chk("resp_rd", {30'd0, res_rd}, {30'd0, ins[12:11]});
        chk("flag_z", {31'd0, flag_z}, {31'd0, FLAGS_EN & (exp_d == 16'h0000)});
        chk("flag_n", {31'd0, flag_n}, {31'd0, FLAGS_EN & exp_d[15]});
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("bp_valid", {31'd0, res_valid}, 32'd1);
            chk("bp_data", {16'd0, res_data}, {16'd0, exp_d});
            chk("bp_ready", {31'd0, instr_ready}, 32'd0);
        end
        res_ready = 1'b1;
        @(negedge clk);                       // after result handshake
        chk("post_valid", {31'd0, res_valid}, 32'd0);
        chk("post_ready", {31'd0, instr_ready}, 32'd1);
        rf_m[ins[12:11]] = int'(exp_d);
    endtask

    typedef struct {
        logic [15:0] ins;
        logic [15:0] exp_d;
    } vec_t;

    vec_t tbl [7];

    initial begin
        logic [15:0] ins, ins2;
        tbl[0] = '{enc(2'd0, 1'b1, 2'd1, 2'd0, 2'd0, 7'd10),   16'h000A}; // r1 = r0 + 10
        tbl[1] = '{enc(2'd1, 1'b1, 2'd2, 2'd1, 2'd0, 7'd5),    16'h0005}; // r2 = r1 - 5
        tbl[2] = '{enc(2'd1, 1'b0, 2'd3, 2'd0, 2'd1, 7'd0),    16'hFFF6}; // r3 = r0 - r1
        tbl[3] = '{enc(2'd3, 1'b1, 2'd1, 2'd0, 2'd0, 7'h7F),   16'h007F}; // r1 = r0 | 0x7F
        tbl[4] = '{enc(2'd2, 1'b1, 2'd2, 2'd1, 2'd0, 7'h0F),   16'h000F}; // r2 = r1 & 0x0F
        tbl[5] = '{enc(2'd1, 1'b0, 2'd0, 2'd2, 2'd2, 7'd0),    16'h0000}; // r0 = r2 - r2
        tbl[6] = '{enc(2'd0, 1'b0, 2'd1, 2'd1, 2'd1, 7'd0),    16'h00FE}; // r1 = r1 + r1
        for (int i = 0; i < 4; i++) rf_m[i] = 0;

        // Reset held for 3 cycles.
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_ready", {31'd0, instr_ready}, 32'd1);
        chk("rst_valid", {31'd0, res_valid}, 32'd0);
        chk("rst_outs", {res_data | alu_a, alu_b}, 32'd0);
        chk("rst_small", {26'd0, res_rd, alu_op, flag_z, flag_n}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("rel_ready", {31'd0, instr_ready}, 32'd1);
        // Every register reads 0 after reset.
        for (int r = 0; r < 4; r++)
            run_instr(enc(2'd3, 1'b1, 2'(r), 2'(r), 2'd0, 7'd0), 16'h0000, 0, 16'h0000, 1'b0);

        // Directed table.
        for (int i = 0; i < 7; i++)
            run_instr(tbl[i].ins, tbl[i].exp_d, 0, 16'h0000, 1'b0);

        // Backpressure with a second instruction waiting on instr_valid.
        ins  = enc(2'd0, 1'b1, 2'd2, 2'd2, 2'd0, 7'd3);
        ins2 = enc(2'd2, 1'b0, 2'd3, 2'd2, 2'd1, 7'd0);
        run_instr(ins, 16'(model_res(ins)), 5, ins2, 1'b1);
        run_instr(ins2, 16'(model_res(ins2)), 0, 16'h0000, 1'b0);

        // Reset during EXEC drops the instruction.
        ins = enc(2'd0, 1'b1, 2'd3, 2'd0, 2'd0, 7'h55);
        instr = ins;
        instr_valid = 1'b1;
        @(negedge clk);
        instr_valid = 1'b0;
        chk("mid_exec_b", {16'd0, alu_b}, 32'h0000_0055);
        rst = 1'b1;
        #1;
        chk("mid_rst_ready", {31'd0, instr_ready}, 32'd1);
        chk("mid_rst_valid", {31'd0, res_valid}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) rf_m[i] = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("mid_no_resp", {31'd0, res_valid}, 32'd0);
        end
        chk("mid_flags", {30'd0, flag_z, flag_n}, 32'd0);
        run_instr(enc(2'd3, 1'b1, 2'd3, 2'd3, 2'd0, 7'd0), 16'h0000, 0, 16'h0000, 1'b0);

        // Randomized instructions against the reference model.
        for (int i = 0; i < 40; i++) begin
            ins = 16'($urandom);
            run_instr(ins, 16'(model_res(ins)), int'($urandom_range(0, 2)), 16'h0000, 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
